// File: rtl/mac_result_collector.sv
// mac_result_collector: slices the free-running MAC accumulator into one
// dot-product result per vector and queues results behind valid/ready.
// Optional feature: define MAC_COLLECT_SEQ_EN to add a 4-bit capture
// sequence tag (res_seq) stored alongside each FIFO entry.
module mac_result_collector #(
    parameter int unsigned ACC_W      = 10,
    parameter int unsigned VEC_LEN    = 4,
    parameter int unsigned MAC_LAT    = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic             clr,
    input  logic [ACC_W-1:0] acc_in,
    output logic [ACC_W-1:0] res_data,
    output logic             res_valid,
    input  logic             res_ready,
`ifdef MAC_COLLECT_SEQ_EN
    output logic [3:0]       res_seq,
`endif
    output logic             overflow
);

    localparam int unsigned CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);

    // element tracking
    logic [MAC_LAT-1:0] dline;
    logic [MAC_LAT-1:0] dline_nxt_c;
    logic               vld_d_c;
    logic [CNT_W-1:0]   cnt;
    logic [ACC_W-1:0]   base;

    // result FIFO
    logic [ACC_W-1:0]   mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   rd_ptr_nxt_c;
    logic [OCC_W-1:0]   occ;
    logic [OCC_W-1:0]   occ_after_pop_c;
    logic [OCC_W-1:0]   occ_nxt_c;
    logic [ACC_W-1:0]   head_data_nxt_c;

    logic               capture_c;
    logic               full_c;
    logic               pop_c;
    logic               push_c;
    logic               drop_c;
    logic [ACC_W-1:0]   result_c;

`ifdef MAC_COLLECT_SEQ_EN
    logic [3:0]         seq;
    logic [3:0]         mem_seq [FIFO_DEPTH];
    logic [3:0]         head_seq_nxt_c;
`endif

    // Capture/push decisions and next FIFO head
    always_comb begin
        dline_nxt_c     = MAC_LAT'({dline, op_valid});
        vld_d_c         = dline[MAC_LAT-1];
        capture_c       = vld_d_c && (cnt == LAST_IDX) && !clr;
        full_c          = (occ == FULL_OCC);
        pop_c           = res_valid && res_ready;
        push_c          = capture_c && (!full_c || pop_c);
        drop_c          = capture_c && full_c && !pop_c;
        result_c        = acc_in - base;
        occ_after_pop_c = occ - OCC_W'(pop_c);
        occ_nxt_c       = occ_after_pop_c + OCC_W'(push_c);
        rd_ptr_nxt_c    = pop_c ? (rd_ptr + PTR_W'(1)) : rd_ptr;
        head_data_nxt_c = res_data;
`ifdef MAC_COLLECT_SEQ_EN
        head_seq_nxt_c  = res_seq;
`endif
        // An empty queue after the pop means the new push goes straight to the head
        if (occ_after_pop_c != '0) begin
            head_data_nxt_c = mem_data[rd_ptr_nxt_c];
`ifdef MAC_COLLECT_SEQ_EN
            head_seq_nxt_c  = mem_seq[rd_ptr_nxt_c];
`endif
        end else if (push_c) begin
            head_data_nxt_c = result_c;
`ifdef MAC_COLLECT_SEQ_EN
            head_seq_nxt_c  = seq;
`endif
        end
    end

    // Latency delay line, element counter, base tracking and sticky overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dline    <= '0;
            cnt      <= '0;
            base     <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            dline    <= '0;
            cnt      <= '0;
            base     <= acc_in;
            overflow <= 1'b0;
        end else begin
            dline <= dline_nxt_c;
            if (capture_c) begin
                cnt  <= '0;
                base <= acc_in;
            end else if (vld_d_c) begin
                cnt  <= cnt + CNT_W'(1);
            end else if (cnt == '0) begin
                base <= acc_in;
            end
            if (drop_c) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef MAC_COLLECT_SEQ_EN
    // Capture sequence tag; counts dropped captures too so gaps expose drops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq <= '0;
        end else if (clr) begin
            seq <= '0;
        end else if (capture_c) begin
            seq <= seq + 4'(1);
        end
    end
`endif

    // FIFO pointers, occupancy and registered head
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            res_data  <= '0;
            res_valid <= 1'b0;
`ifdef MAC_COLLECT_SEQ_EN
            res_seq   <= '0;
`endif
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr    <= rd_ptr_nxt_c;
            occ       <= occ_nxt_c;
            res_data  <= head_data_nxt_c;
            res_valid <= (occ_nxt_c != '0);
`ifdef MAC_COLLECT_SEQ_EN
            res_seq   <= head_seq_nxt_c;
`endif
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_data[wr_ptr] <= result_c;
`ifdef MAC_COLLECT_SEQ_EN
            mem_seq[wr_ptr]  <= seq;
`endif
        end
    end

endmodule

// File: doc/mac_result_collector.md
# mac_result_collector

Downstream stage of the pipelined 4x4 MAC. Turns the MAC's free-running 10-bit accumulator output into one dot-product result per vector of `VEC_LEN` operand pairs. Tracks the MAC's fixed 3-cycle operand-to-accumulator latency. Buffers results in a small FIFO with a valid/ready output handshake.

## Interface
- `ACC_W`, 10, accumulator width; matches the MAC output.
- `VEC_LEN`, 4, operand pairs per vector (>=1).
- `MAC_LAT`, 3, cycles from an operand pair presented to the MAC until it is reflected on `acc_in`.
- `FIFO_DEPTH`, 4, result FIFO entries (power of two).
- `clk`  in  1  clock; rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `op_valid`  in  1  a real operand pair is driven into the MAC this cycle. The feeder drives a=b=0 when low.
- `clr`  in  1  synchronous: abort the current vector, clear `overflow`.
- `acc_in`  in  ACC_W  MAC accumulator output (`cin`).
- `res_data`  out  ACC_W  head-of-FIFO dot-product result.
- `res_valid`  out  1  FIFO non-empty.
- `res_ready`  in  1  consumer accepts `res_data` when high with `res_valid`.
- `overflow`  out  1  sticky: a result was dropped because the FIFO was full.

## Operation
- Delay line: `op_valid` passes through a `MAC_LAT`-stage shift register to produce `vld_d`. `vld_d` is high in exactly the cycle that `acc_in` first includes that element.
- Element counter `cnt` runs 0..VEC_LEN-1. It increments on `vld_d`.
- Base register `base`:
  - When `cnt==0` and `!vld_d`, `base <= acc_in` every cycle. This absorbs discarded in-flight elements and zero cycles.
  - Otherwise `base` holds.
- Capture occurs when `vld_d && cnt==VEC_LEN-1`:
  - result = (`acc_in - base`) mod 2^ACC_W. Wrap-around of the accumulator is therefore transparent.
  - Push the result into the FIFO.
  - `base <= acc_in`, `cnt <= 0`.
- Push and pop rules:
  - If the FIFO is full at capture and no pop occurs in the same cycle, the result is dropped and `overflow <= 1`.
  - A push and a pop in the same cycle are both performed, whether the FIFO is full or not; occupancy is unchanged.
  - Pop when `res_valid && res_ready`. `res_data` is the registered FIFO head, stable while `res_valid && !res_ready`.
- `clr`:
  - Sets `cnt <= 0`, zeros the delay line, sets `overflow <= 0`, and sets `base <= acc_in`.
  - Elements already inside the MAC are absorbed by the base-follow rule.
  - FIFO contents are retained.
  - If `clr` and a capture coincide, `clr` wins and no push occurs.
- Reset:
  - `res_data=0`, `res_valid=0`, `overflow=0`, `cnt=0`, `base=0`, delay line 0, FIFO empty.
  - The MAC must be held in reset whenever this block is, so `acc_in=0` on exit.
  - Reset mid-vector discards all partial and buffered results.

## Timing
- An `op_valid` in cycle t gives `vld_d` in cycle t+MAC_LAT.
- The last element of a vector has `op_valid` in cycle t. The result is pushed at the end of cycle t+3, and `res_valid` goes high in cycle t+4 if the FIFO was empty.
- Back-to-back vectors with `op_valid` held continuously: one result every `VEC_LEN` cycles, with no bubble.
- FIFO throughput is one push and one pop per cycle. With `VEC_LEN=1`, a result is pushed every cycle.

## Configuration
- `MAC_COLLECT_SEQ_EN` defined:
  - Adds output `res_seq` [3:0], stored alongside each FIFO entry.
  - The tag comes from a 4-bit counter that increments on every capture, including dropped ones, and wraps 15 -> 0.
  - Reset and `clr` set the counter to 0.
  - A gap in `res_seq` reveals drops.
- `MAC_COLLECT_SEQ_EN` undefined: no `res_seq` port and no counter; all other behaviour is identical.

## Test plan
- Vector one: reset, then `op_valid` in cycles 0-3 with pairs (1,2), (3,4), (5,6), (7,8) and `res_ready=1`. Required: `res_data=100` with `res_valid` high in cycle 7 only.
- Vector two, following vector one: (15,15) x4 in cycles 4-7. The accumulator reaches 1000. Required: result 900.
- Wrap-around: a third (15,15) x4 takes `acc_in` to 876 after wrap. Required: result 900.
- Backpressure: `res_ready=0` over 5 vectors of (1,1) x4. Required:
  - 4 results of value 4 are held.
  - `overflow=1` after the 5th capture.
  - Draining yields exactly 4 entries.
  - With SEQ_EN, the seqs are 0,1,2,3.
- Mid-vector clear: `clr` after 2 of 4 valid elements with elements still in flight, then a fresh vector (2,3) x4. Required: result 24, and nothing pushed for the aborted vector.
- Mid-vector reset: assert `reset` during cycle 2 of a vector. Required: all outputs are 0 immediately (asynchronous), and the next full vector produces its correct value.
